// File: rtl/operand_fetch_unit.sv
// rtl/operand_fetch_unit.sv - operand fetch with write-hazard stall, timeout and stall counter
// Reads one or two GPRs from the flattened bank once their pending writes clear.
module operand_fetch_unit #(
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   src_a_sel,
  input  logic [2:0]   src_b_sel,
  input  logic         two_operand,
  input  logic [255:0] reg_bank,
  input  logic [7:0]   pending_write_mask,
  output logic [31:0]  op_a,
  output logic [31:0]  op_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   stall_count,
  output logic         hazard_timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH_A = 2'd1,
    FETCH_B = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

  state_t      state;
  logic [2:0]  sel_a_q;
  logic [2:0]  sel_b_q;
  logic        two_q;
  logic [7:0]  timer;

  logic [2:0]  cur_sel;
  logic        cur_pending;
  logic [31:0] cur_word;
  logic        stall;

  // Both fetch states share one hazard check; only the selected index differs.
  assign cur_sel     = (state == FETCH_B) ? sel_b_q : sel_a_q;
  assign cur_pending = pending_write_mask[cur_sel];
  assign cur_word    = reg_bank[{cur_sel, 5'd0} +: 32];
  assign stall       = cur_pending && (timer < LIMIT);
  assign req_ready   = (state == IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      sel_a_q        <= 3'd0;
      sel_b_q        <= 3'd0;
      two_q          <= 1'b0;
      timer          <= 8'd0;
      op_a           <= 32'd0;
      op_b           <= 32'd0;
      out_valid      <= 1'b0;
      stall_count    <= 8'd0;
      hazard_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            sel_a_q <= src_a_sel;
            sel_b_q <= src_b_sel;
            two_q   <= two_operand;
            timer   <= 8'd0;
            state   <= FETCH_A;
          end
        end
        FETCH_A, FETCH_B: begin
          if (stall) begin
            timer <= timer + 8'd1;
            if (stall_count != 8'hFF) begin
              stall_count <= stall_count + 8'd1;
            end
          end else begin
            timer <= 8'd0;
            if (timer == LIMIT) begin
              hazard_timeout <= 1'b1;
            end
            if (state == FETCH_A) begin
              op_a <= cur_word;
              if (two_q) begin
                state <= FETCH_B;
              end else begin
                op_b  <= 32'd0;
                state <= HOLD;
              end
            end else begin
              op_b  <= cur_word;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          // out_valid rises on the first HOLD edge so it is a clean register output.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
